// File: rtl/packet_vomiter_burst_sched_if.sv
// Handshake bundle between the vomiter register block, the burst scheduler and the vomiter datapath.
// PKT_SCHED_STATS_EN adds the packet-sent statistics counter signals.
interface packet_vomiter_burst_sched_if #(
    parameter int CNT_WIDTH = 32,
    parameter int GAP_WIDTH = 16
);
    logic                 cfg_start;
    logic                 cfg_stop;
    logic [CNT_WIDTH-1:0] cfg_burst_len;
    logic [CNT_WIDTH-1:0] cfg_num_bursts;
    logic [GAP_WIDTH-1:0] cfg_ipg;
    logic [GAP_WIDTH-1:0] cfg_ibg;
    logic                 pkt_req;
    logic                 pkt_ack;
    logic                 pkt_done;
    logic                 busy;
    logic                 done_pulse;
    logic [CNT_WIDTH-1:0] pkt_idx;
    logic [CNT_WIDTH-1:0] burst_idx;
`ifdef PKT_SCHED_STATS_EN
    logic                 pkt_sent_clear;
    logic [CNT_WIDTH-1:0] pkt_sent_cnt;
`endif

    // master: the scheduler itself; slave: host and datapath side
    modport master (
        input  cfg_start, cfg_stop, cfg_burst_len, cfg_num_bursts, cfg_ipg, cfg_ibg,
        input  pkt_ack, pkt_done,
`ifdef PKT_SCHED_STATS_EN
        input  pkt_sent_clear,
        output pkt_sent_cnt,
`endif
        output pkt_req, busy, done_pulse, pkt_idx, burst_idx
    );

    modport slave (
        output cfg_start, cfg_stop, cfg_burst_len, cfg_num_bursts, cfg_ipg, cfg_ibg,
        output pkt_ack, pkt_done,
`ifdef PKT_SCHED_STATS_EN
        output pkt_sent_clear,
        input  pkt_sent_cnt,
`endif
        input  pkt_req, busy, done_pulse, pkt_idx, burst_idx
    );
endinterface

// File: rtl/packet_vomiter_burst_sched.sv
// Packet vomiter burst scheduler: one request at a time, packets per burst, bursts per run, idle gaps.
// PKT_SCHED_STATS_EN adds a saturating count of completed packets with a clear input.
//
// state     | meaning
// S_IDLE    | no run; waits for cfg_start
// S_REQ     | pkt_req held high until pkt_ack
// S_WAIT_DONE | request accepted, waiting for pkt_done
// S_IPG     | idle gap between packets of a burst
// S_IBG     | idle gap between bursts
// S_FINISH  | one-cycle done_pulse, then back to idle
module packet_vomiter_burst_sched #(
    parameter int CNT_WIDTH = 32,
    parameter int GAP_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    packet_vomiter_burst_sched_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DONE,
        S_IPG,
        S_IBG,
        S_FINISH
    } state_t;

    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] len_q, num_q;
    logic [GAP_WIDTH-1:0] ipg_q, ibg_q;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [CNT_WIDTH-1:0] pkt_idx, burst_idx;
    logic                 stop_pending;

    logic [CNT_WIDTH-1:0] pkt_idx_inc, burst_idx_inc;
    logic                 done_evt, burst_end, run_end, stop_eff;

    assign pkt_idx_inc   = pkt_idx + CNT_WIDTH'(1);
    assign burst_idx_inc = burst_idx + CNT_WIDTH'(1);
    // ack and done in the same REQ cycle count as a completed packet
    assign done_evt  = ((state == S_REQ) && bus.pkt_ack && bus.pkt_done) ||
                       ((state == S_WAIT_DONE) && bus.pkt_done);
    assign burst_end = (pkt_idx_inc == len_q);
    assign run_end   = burst_end && (num_q != '0) && (burst_idx_inc == num_q);
    // a stop arriving together with pkt_done still ends the run at that packet
    assign stop_eff  = stop_pending || bus.cfg_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            len_q        <= '0;
            num_q        <= '0;
            ipg_q        <= '0;
            ibg_q        <= '0;
            gap_cnt      <= '0;
            pkt_idx      <= '0;
            burst_idx    <= '0;
            stop_pending <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        len_q <= bus.cfg_burst_len;
                        num_q <= bus.cfg_num_bursts;
                        ipg_q <= bus.cfg_ipg;
                        ibg_q <= bus.cfg_ibg;
                        if (bus.cfg_burst_len != '0) begin
                            pkt_idx   <= '0;
                            burst_idx <= '0;
                        end
                    end
                end
                S_REQ, S_WAIT_DONE: begin
                    if (bus.cfg_stop) stop_pending <= 1'b1;
                end
                S_IPG, S_IBG: gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                S_FINISH:     stop_pending <= 1'b0;
                default: ;
            endcase
            if (done_evt) begin
                if (burst_end) begin
                    pkt_idx   <= '0;
                    burst_idx <= burst_idx_inc;
                    gap_cnt   <= ibg_q - GAP_WIDTH'(1);
                end else begin
                    pkt_idx <= pkt_idx_inc;
                    gap_cnt <= ipg_q - GAP_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.cfg_start)
                    state_n = (bus.cfg_burst_len != '0) ? S_REQ : S_FINISH;
            end
            S_REQ: begin
                if (bus.pkt_ack) state_n = S_WAIT_DONE;
            end
            S_IPG, S_IBG: begin
                if (bus.cfg_stop)       state_n = S_FINISH;
                else if (gap_cnt == '0) state_n = S_REQ;
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = state;
        endcase
        if (done_evt) begin
            if (stop_eff || run_end) state_n = S_FINISH;
            else if (burst_end)      state_n = (ibg_q == '0) ? S_REQ : S_IBG;
            else                     state_n = (ipg_q == '0) ? S_REQ : S_IPG;
        end
    end

    assign bus.pkt_req    = (state == S_REQ);
    assign bus.busy       = (state != S_IDLE);
    assign bus.done_pulse = (state == S_FINISH);
    assign bus.pkt_idx    = pkt_idx;
    assign bus.burst_idx  = burst_idx;

`ifdef PKT_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] sent_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            sent_cnt <= '0;
        else if (bus.pkt_sent_clear)
            sent_cnt <= done_evt ? CNT_WIDTH'(1) : '0;
        else if (done_evt && (sent_cnt != '1))
            sent_cnt <= sent_cnt + CNT_WIDTH'(1);
    end

    assign bus.pkt_sent_cnt = sent_cnt;
`endif
endmodule

// File: tb/tb_packet_vomiter_burst_sched.sv
// Directed bench for packet_vomiter_burst_sched: gaps, stop handling, no-op run, reset mid-run.
// With PKT_SCHED_STATS_EN defined the packet-sent counter is exercised as well.
module tb_packet_vomiter_burst_sched;
    localparam int CW = 32;
    localparam int GW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    int   n_dp = 0;

    packet_vomiter_burst_sched_if #(.CNT_WIDTH(CW), .GAP_WIDTH(GW)) bus ();

    packet_vomiter_burst_sched #(.CNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // observation counters: accepted requests and done pulses
    always @(posedge clk) begin
        if (bus.pkt_req && bus.pkt_ack) n_acc++;
        if (bus.done_pulse) n_dp++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic start_run(input int len, input int nb, input int ipg, input int ibg);
        bus.cfg_burst_len  = CW'(len);
        bus.cfg_num_bursts = CW'(nb);
        bus.cfg_ipg        = GW'(ipg);
        bus.cfg_ibg        = GW'(ibg);
        bus.cfg_start      = 1'b1;
        step();
        bus.cfg_start      = 1'b0;
    endtask

    // serve one packet; gap = idle cycles after pkt_done before pkt_req or done_pulse
    task automatic serve(input int ack_dly, input int done_dly, input int max_gap, output int gap);
        int n;
        n = 0;
        while (!bus.pkt_req && n < 50) begin
            step();
            n++;
        end
        check("req_seen", 64'(bus.pkt_req), 64'd1);
        repeat (ack_dly) step();
        check("req_held", 64'(bus.pkt_req), 64'd1);
        bus.pkt_ack = 1'b1;
        if (done_dly == 0) bus.pkt_done = 1'b1;
        step();
        bus.pkt_ack  = 1'b0;
        bus.pkt_done = 1'b0;
        if (done_dly > 0) begin
            repeat (done_dly - 1) step();
            bus.pkt_done = 1'b1;
            step();
            bus.pkt_done = 1'b0;
        end
        gap = 0;
        while (!bus.pkt_req && !bus.done_pulse && gap < max_gap) begin
            step();
            gap++;
        end
    endtask

    initial begin
        int gap;
        int base_acc;
        int base_dp;
        int exp_gap1 [6];

        bus.cfg_start      = 1'b0;
        bus.cfg_stop       = 1'b0;
        bus.cfg_burst_len  = '0;
        bus.cfg_num_bursts = '0;
        bus.cfg_ipg        = '0;
        bus.cfg_ibg        = '0;
        bus.pkt_ack        = 1'b0;
        bus.pkt_done       = 1'b0;
`ifdef PKT_SCHED_STATS_EN
        bus.pkt_sent_clear = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check("rst_req", 64'(bus.pkt_req), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done_pulse), 64'd0);
        check("rst_pkt_idx", 64'(bus.pkt_idx), 64'd0);
        check("rst_burst_idx", 64'(bus.burst_idx), 64'd0);
`ifdef PKT_SCHED_STATS_EN
        check("rst_sent_cnt", 64'(bus.pkt_sent_cnt), 64'd0);
`endif

        // 1: 3 packets x 2 bursts, ipg 2, ibg 5, ack 1 after req, done 4 after ack
        exp_gap1 = '{2, 2, 5, 2, 2, 0};
        base_acc = n_acc;
        base_dp  = n_dp;
        start_run(3, 2, 2, 5);
        check("t1_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 6; i++) begin
            serve(1, 4, 20, gap);
            check($sformatf("t1_gap%0d", i), 64'(gap), 64'(exp_gap1[i]));
            if (i == 0) check("t1_pkt_idx_mid", 64'(bus.pkt_idx), 64'd1);
            if (i == 2) check("t1_burst_idx_mid", 64'(bus.burst_idx), 64'd1);
        end
        check("t1_done_pulse", 64'(bus.done_pulse), 64'd1);
        check("t1_burst_idx", 64'(bus.burst_idx), 64'd2);
        check("t1_pkt_idx", 64'(bus.pkt_idx), 64'd0);
        step();
        check("t1_idle", 64'(bus.busy), 64'd0);
        repeat (3) step();
        check("t1_reqs", 64'(n_acc - base_acc), 64'd6);
        check("t1_dps", 64'(n_dp - base_dp), 64'd1);

        // 2: zero gaps, ack+done with req; cfg changes while busy are ignored
        base_acc = n_acc;
        start_run(2, 2, 0, 0);
        bus.cfg_burst_len  = CW'(1);
        bus.cfg_num_bursts = CW'(1);
        bus.cfg_ipg        = GW'(7);
        for (int i = 0; i < 4; i++) begin
            serve(0, 0, 20, gap);
            check($sformatf("t2_gap%0d", i), 64'(gap), 64'd0);
        end
        check("t2_done_pulse", 64'(bus.done_pulse), 64'd1);
        check("t2_burst_idx", 64'(bus.burst_idx), 64'd2);
        step();
        check("t2_reqs", 64'(n_acc - base_acc), 64'd4);

        // 3: unlimited run, stop while waiting for pkt_done
        base_acc = n_acc;
        start_run(4, 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            serve(1, 2, 20, gap);
            check($sformatf("t3_gap%0d", i), 64'(gap), 64'd1);
        end
        check("t3_burst_idx_wrapless", 64'(bus.burst_idx), 64'd1);
        check("t3_pkt_idx5", 64'(bus.pkt_idx), 64'd1);
        bus.pkt_ack = 1'b1;
        step();
        bus.pkt_ack  = 1'b0;
        bus.cfg_stop = 1'b1;
        step();
        bus.cfg_stop = 1'b0;
        step();
        check("t3_wait_busy", 64'(bus.busy), 64'd1);
        check("t3_wait_done", 64'(bus.done_pulse), 64'd0);
        bus.pkt_done = 1'b1;
        step();
        bus.pkt_done = 1'b0;
        check("t3_done_pulse", 64'(bus.done_pulse), 64'd1);
        check("t3_pkt_idx", 64'(bus.pkt_idx), 64'd2);
        step();
        check("t3_idle", 64'(bus.busy), 64'd0);
        repeat (8) step();
        check("t3_reqs", 64'(n_acc - base_acc), 64'd6);

        // 4: stop during a long inter-burst gap
        base_acc = n_acc;
        start_run(1, 0, 0, 100);
        serve(0, 1, 10, gap);
        check("t4_in_ibg", 64'(gap), 64'd10);
        check("t4_busy", 64'(bus.busy), 64'd1);
        bus.cfg_stop = 1'b1;
        step();
        bus.cfg_stop = 1'b0;
        check("t4_done_pulse", 64'(bus.done_pulse), 64'd1);
        step();
        check("t4_idle", 64'(bus.busy), 64'd0);
        repeat (10) step();
        check("t4_reqs", 64'(n_acc - base_acc), 64'd1);

        // 5: zero-length run; a start during FINISH is ignored
        base_acc = n_acc;
        start_run(0, 3, 0, 0);
        check("t5_done_pulse", 64'(bus.done_pulse), 64'd1);
        check("t5_req", 64'(bus.pkt_req), 64'd0);
        bus.cfg_burst_len = CW'(3);
        bus.cfg_start     = 1'b1;
        step();
        bus.cfg_start     = 1'b0;
        check("t5_idle", 64'(bus.busy), 64'd0);
        check("t5_done_once", 64'(bus.done_pulse), 64'd0);
        repeat (4) step();
        check("t5_no_req", 64'(bus.pkt_req), 64'd0);
        check("t5_reqs", 64'(n_acc - base_acc), 64'd0);

        // 6: reset while pkt_req is high
        base_dp = n_dp;
        start_run(3, 1, 0, 0);
        serve(0, 1, 5, gap);
        check("t6_req_up", 64'(bus.pkt_req), 64'd1);
        check("t6_pkt_idx", 64'(bus.pkt_idx), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_req", 64'(bus.pkt_req), 64'd0);
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_pkt_idx0", 64'(bus.pkt_idx), 64'd0);
        check("t6_burst_idx0", 64'(bus.burst_idx), 64'd0);
        repeat (3) step();
        check("t6_no_dp", 64'(n_dp - base_dp), 64'd0);

`ifdef PKT_SCHED_STATS_EN
        check("st_after_rst", 64'(bus.pkt_sent_cnt), 64'd0);
        start_run(2, 1, 0, 0);
        bus.pkt_ack        = 1'b1;
        bus.pkt_done       = 1'b1;
        bus.pkt_sent_clear = 1'b1;
        step();
        bus.pkt_sent_clear = 1'b0;
        check("st_clear_done", 64'(bus.pkt_sent_cnt), 64'd1);
        step();
        bus.pkt_ack  = 1'b0;
        bus.pkt_done = 1'b0;
        check("st_count2", 64'(bus.pkt_sent_cnt), 64'd2);
        check("st_done_pulse", 64'(bus.done_pulse), 64'd1);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
